// File: rtl/out_port_arbiter.sv
// -----------------------------------------------------------------------------
// out_port_arbiter
//   Shares the 16-bit output port register between NUM_REQ requesters. Each
//   requester asks for a masked write. One winner per transaction is chosen
//   round-robin, and its data is merged with a shadow copy of the port value.
//   The merged value is then issued as a single-cycle bus write to OUT_ADDR.
//   A transaction always takes three cycles: IDLE (arbitrate), WRITE (bus
//   write), ACK (pulse the winner's ack).
//
// Ports
//   clk      in   1            system clock, rising edge
//   reset    in   1            asynchronous, active-low (0 = in reset)
//   req      in   NUM_REQ      per-requester write request, level
//   wdata    in   16*NUM_REQ   write data, requester i at [16i+15:16i]
//   wmask    in   16*NUM_REQ   bit mask, 1 = replace that port bit
//   ack      out  NUM_REQ      one-cycle pulse when a write is committed
//   bus_out  out  32           to port driver bus_in (upper 16 bits zero)
//   adress   out  32           to port driver adress
//   busy     out  1            high while a transaction is in progress
//   shadow   out  16           last value written to the port
// -----------------------------------------------------------------------------
module out_port_arbiter #(
  parameter int          NUM_REQ     = 4,
  parameter logic [31:0] OUT_ADDR    = 32'd8,
  parameter logic [31:0] IDLE_ADDR   = 32'd0,
  parameter logic [15:0] SHADOW_INIT = 16'h0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [16*NUM_REQ-1:0]   wdata,
  input  logic [16*NUM_REQ-1:0]   wmask,
  output logic [NUM_REQ-1:0]      ack,
  output logic [31:0]             bus_out,
  output logic [31:0]             adress,
  output logic                    busy,
  output logic [15:0]             shadow
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;       // first requester to consider in the next search
  logic [PW-1:0] grant;     // winner of the transaction in flight
  logic [15:0]   wr;        // merged value being written

  logic [15:0]   wd [NUM_REQ];
  logic [15:0]   wm [NUM_REQ];

  logic [PW-1:0] pick;
  logic [15:0]   merged;
  logic          found;
  logic [PW:0]   cand_sum;
  logic [PW-1:0] cand;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign wd[i] = wdata[16*i +: 16];
    assign wm[i] = wmask[16*i +: 16];
  end

  // Round-robin search starting at ptr, wrapping at NUM_REQ-1 -> 0. The
  // merge is computed here so the IDLE state can register it directly.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    pick     = '0;
    found    = 1'b0;
    merged   = shadow;
    cand_sum = '0;
    cand     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_sum = {1'b0, ptr} + (PW+1)'(off);
      if (cand_sum >= (PW+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (PW+1)'(NUM_REQ);
      end
      cand = cand_sum[PW-1:0];
      if (!found && req[cand]) begin
        found  = 1'b1;
        pick   = cand;
        merged = (shadow & ~wm[cand]) | (wd[cand] & wm[cand]);
      end
    end
  end

  // All outputs are registers updated on state transitions, so nothing on
  // the output side depends combinationally on req/wdata/wmask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state   <= IDLE;
      ptr     <= '0;
      grant   <= '0;
      wr      <= '0;
      ack     <= '0;
      bus_out <= '0;
      adress  <= IDLE_ADDR;
      busy    <= 1'b0;
      shadow  <= SHADOW_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant   <= pick;
            wr      <= merged;
            bus_out <= {16'h0000, merged};
            adress  <= OUT_ADDR;
            busy    <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          // The port driver latches the bus on this edge; mirror it.
          shadow  <= wr;
          adress  <= IDLE_ADDR;
          bus_out <= '0;
          ack     <= NUM_REQ'(1) << grant;
          state   <= ACK;
        end
        ACK: begin
          ack   <= '0;
          busy  <= 1'b0;
          ptr   <= (grant == PW'(NUM_REQ-1)) ? '0 : grant + PW'(1);
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_out_port_arbiter
//   Directed bench for out_port_arbiter. Stimulus pushes the hand-computed
//   expected write (winner, merged value) into a queue; a monitor pops an
//   entry whenever the DUT drives a bus write, checks the bus data, then
//   checks the ack pulse and shadow on the following cycle.
// -----------------------------------------------------------------------------
module tb_out_port_arbiter;

  localparam int          NUM_REQ   = 4;
  localparam logic [31:0] OUT_ADDR  = 32'd8;
  localparam logic [31:0] IDLE_ADDR = 32'd0;

  logic                  clk;
  logic                  reset;
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] wdata;
  logic [16*NUM_REQ-1:0] wmask;
  logic [NUM_REQ-1:0]    ack;
  logic [31:0]           bus_out;
  logic [31:0]           adress;
  logic                  busy;
  logic [15:0]           shadow;

  out_port_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .OUT_ADDR   (OUT_ADDR),
    .IDLE_ADDR  (IDLE_ADDR),
    .SHADOW_INIT(16'h0000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .wdata  (wdata),
    .wmask  (wmask),
    .ack    (ack),
    .bus_out(bus_out),
    .adress (adress),
    .busy   (busy),
    .shadow (shadow)
  );

  typedef struct {
    int          g;
    logic [15:0] data;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    fails  = 0;
  int    cyc    = 0;
  int    last_ack_cyc = 0;
  int    prev_ack_cyc = 0;
  logic  ack_pending  = 1'b0;
  logic [NUM_REQ-1:0] exp_ack;
  logic [15:0]        exp_shadow;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset) begin
      ack_pending = 1'b0;
    end else begin
      if (ack_pending) begin
        check("ack", 32'(ack), 32'(exp_ack));
        check("shadow", 32'(shadow), 32'(exp_shadow));
        check("adress_after_write", adress, IDLE_ADDR);
        ack_pending  = 1'b0;
        prev_ack_cyc = last_ack_cyc;
        last_ack_cyc = cyc;
      end else if (ack != '0) begin
        check("spurious_ack", 32'(ack), 32'd0);
      end
      if (adress == OUT_ADDR) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", adress, IDLE_ADDR);
        end else begin
          e = exp_q.pop_front();
          check("bus_out", bus_out, {16'h0000, e.data});
          check("busy_in_write", 32'(busy), 32'd1);
          exp_ack     = NUM_REQ'(1) << e.g;
          exp_shadow  = e.data;
          ack_pending = 1'b1;
        end
      end
    end
  end

  task automatic set_data(input int i, input logic [15:0] d, input logic [15:0] m);
    wdata[16*i +: 16] = d;
    wmask[16*i +: 16] = m;
  endtask

  task automatic expect_w(input int g, input logic [15:0] d);
    exp_t e;
    e.g    = g;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Hold the requested bits, dropping each one during its ack cycle.
  task automatic serve(input logic [NUM_REQ-1:0] r);
    int n;
    req = r;
    n   = 0;
    while (req != '0 && n < 60) begin
      @(negedge clk);
      req = req & ~ack;
      n++;
    end
    if (req != '0) begin
      check("ack_timeout", 32'(req), 32'd0);
      req = '0;
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req   = '0;
    wdata = '0;
    wmask = '0;
    repeat (3) @(negedge clk);
    check("rst_ack",     32'(ack),    32'd0);
    check("rst_bus_out", bus_out,     32'd0);
    check("rst_adress",  adress,      IDLE_ADDR);
    check("rst_busy",    32'(busy),   32'd0);
    check("rst_shadow",  32'(shadow), 32'h0000);
    reset = 1'b1;
    @(negedge clk);

    // Plain overwrite from requester 0.
    set_data(0, 16'hA5A5, 16'hFFFF); expect_w(0, 16'hA5A5); serve(4'b0001);
    // Set shadow to 00FF, then masked upper-byte write from requester 1.
    set_data(0, 16'h00FF, 16'hFFFF); expect_w(0, 16'h00FF); serve(4'b0001);
    set_data(1, 16'hAB00, 16'hFF00); expect_w(1, 16'hABFF); serve(4'b0010);
    // Grant requester 3 so ptr wraps back to 0.
    set_data(3, 16'h1234, 16'hFFFF); expect_w(3, 16'h1234); serve(4'b1000);

    // ptr=0, req=1010: order 1 then 3, acks three cycles apart.
    set_data(1, 16'h5600, 16'hFF00);
    set_data(3, 16'h000F, 16'h000F);
    expect_w(1, 16'h5634);
    expect_w(3, 16'h563F);
    serve(4'b1010);
    check("ack_spacing_1_3", 32'(last_ack_cyc - prev_ack_cyc), 32'd3);

    // All four held for 12 cycles: grants 0,1,2,3 in turn.
    set_data(0, 16'h1111, 16'hF000);
    set_data(1, 16'h2222, 16'h0F00);
    set_data(2, 16'h00C0, 16'h00F0);
    set_data(3, 16'h0004, 16'h000F);
    expect_w(0, 16'h163F);
    expect_w(1, 16'h123F);
    expect_w(2, 16'h12CF);
    expect_w(3, 16'h12C4);
    req = 4'b1111;
    repeat (12) @(negedge clk);
    req = '0;
    wait_idle();
    check("ack_spacing_all", 32'(last_ack_cyc - prev_ack_cyc), 32'd3);
    check("shadow_after_all", 32'(shadow), 32'h12C4);

    // Zero mask: full transaction, port value unchanged.
    set_data(0, 16'h1234, 16'hFFFF); expect_w(0, 16'h1234); serve(4'b0001);
    set_data(0, 16'hFFFF, 16'h0000); expect_w(0, 16'h1234); serve(4'b0001);

    // Reset during WRITE drops the write; re-held req then completes.
    set_data(0, 16'hBEEF, 16'h0FF0);
    req = 4'b0001;
    @(posedge clk);
    #1;
    check("pre_reset_in_write", adress, OUT_ADDR);
    reset = 1'b0;
    #1;
    check("mid_rst_adress", adress,      IDLE_ADDR);
    check("mid_rst_ack",    32'(ack),    32'd0);
    check("mid_rst_busy",   32'(busy),   32'd0);
    check("mid_rst_shadow", 32'(shadow), 32'h0000);
    @(negedge clk);
    reset = 1'b1;
    expect_w(0, 16'h0EE0);
    serve(4'b0001);

    for (int n = 0; n < 20 && (exp_q.size() != 0 || ack_pending); n++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
